cache_dre_refill_ctrl: RTL and testbench



---
 rtl/cache_dre_refill_ctrl.sv | 133 +++++++++++++
 tb/tb_cache_dre_refill_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_dre_refill_ctrl.sv
// Refill-side sequencer for the cache DRE (byte-readable) table: clears the target
// line's readable bits, then marks each word readable as its refill beat lands.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | port owned by read/write side; waiting for a refill command
// CLEAR | writing 0x00 to every DRE pair entry of the line, one per cycle
// FILL  | one DRE write per refill beat; abort ends the line early
// DONE  | one-cycle completion pulse; port handed back
module cache_dre_refill_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rw_idle,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_channel,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  beat_valid,
    output logic                  beat_ready,
    input  logic                  abort,
    output logic                  done,
    output logic                  sel,
    output logic [ADDR_WIDTH-1:0] dre_readAddress,
    output logic [ADDR_WIDTH-1:0] dre_writeAddress,
    output logic [1:0]            dre_readChannel,
    output logic [1:0]            dre_writeChannel,
    output logic                  dre_writeEnable,
    output logic [7:0]            dre_writeData,
    input  logic [7:0]            dre_readData
);

    localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0]      LAST_PAIR = CNT_W'(LINE_WORDS - 2);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, FILL, DONE} state_t;

    state_t                  state;
    state_t                  stateNext;
    logic [ADDR_WIDTH-1:0]   base;
    logic [1:0]              ch;
    logic [CNT_W-1:0]        cnt;
    logic                    cmdAccept;
    logic                    beatAccept;
    logic [ADDR_WIDTH-1:0]   writeAddr;

    // Read data is never consumed here; the refill side only writes the table.
    logic unusedReadData;
    assign unusedReadData = ^dre_readData;

    assign cmdAccept  = (state == IDLE) && cmd_valid && rw_idle;
    assign beatAccept = (state == FILL) && beat_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (cmdAccept) stateNext = CLEAR;
            CLEAR:   if (cnt == LAST_PAIR) stateNext = FILL;
            FILL:    if (abort || (beat_valid && (cnt == LAST_BEAT))) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base <= '0;
            ch   <= '0;
            cnt  <= '0;
        end else begin
            if (cmdAccept) begin
                base <= cmd_addr & ~LINE_MASK;
                ch   <= cmd_channel;
                cnt  <= '0;
            end else if (state == CLEAR) begin
                cnt <= (cnt == LAST_PAIR) ? '0 : cnt + CNT_W'(2);
            end else if (beatAccept) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cmd_ready       = 1'b0;
        beat_ready      = 1'b0;
        done            = 1'b0;
        sel             = 1'b0;
        dre_writeEnable = 1'b0;
        dre_writeData   = 8'h00;
        writeAddr       = base | ADDR_WIDTH'(cnt);
        case (state)
            IDLE: begin
                cmd_ready = rw_idle;
            end
            CLEAR: begin
                sel             = 1'b1;
                dre_writeEnable = 1'b1;
                writeAddr       = base | ADDR_WIDTH'(cnt & ~CNT_W'(1));
            end
            FILL: begin
                sel             = 1'b1;
                beat_ready      = 1'b1;
                dre_writeEnable = beat_valid;
                // Odd word rewrites the whole pair so its in-order even partner stays readable.
                dre_writeData   = cnt[0] ? 8'hFF : 8'h0F;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    assign dre_readAddress  = writeAddr;
    assign dre_writeAddress = writeAddr;
    assign dre_readChannel  = ch;
    assign dre_writeChannel = ch;

endmodule

// File: tb/tb_cache_dre_refill_ctrl.sv
// Bench for cache_dre_refill_ctrl: expected DRE writes queued at stimulus time and
// matched by a write monitor; handshake timing checked along the way.
module tb_cache_dre_refill_ctrl;

    localparam int AW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rw_idle;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_channel;
    logic [AW-1:0] cmd_addr;
    logic          beat_valid;
    logic          beat_ready;
    logic          abort;
    logic          done;
    logic          sel;
    logic [AW-1:0] dre_readAddress;
    logic [AW-1:0] dre_writeAddress;
    logic [1:0]    dre_readChannel;
    logic [1:0]    dre_writeChannel;
    logic          dre_writeEnable;
    logic [7:0]    dre_writeData;
    logic [7:0]    dre_readData;

    cache_dre_refill_ctrl #(.ADDR_WIDTH(AW), .LINE_WORDS(LW)) dut (
        .clk              (clk),
        .rst              (rst),
        .rw_idle          (rw_idle),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_channel      (cmd_channel),
        .cmd_addr         (cmd_addr),
        .beat_valid       (beat_valid),
        .beat_ready       (beat_ready),
        .abort            (abort),
        .done             (done),
        .sel              (sel),
        .dre_readAddress  (dre_readAddress),
        .dre_writeAddress (dre_writeAddress),
        .dre_readChannel  (dre_readChannel),
        .dre_writeChannel (dre_writeChannel),
        .dre_writeEnable  (dre_writeEnable),
        .dre_writeData    (dre_writeData),
        .dre_readData     (dre_readData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    chan;
        logic [7:0]    data;
    } wr_t;

    wr_t           sbq[$];
    int            nChecks = 0;
    int            nErrors = 0;
    logic [AW-1:0] mBase;
    logic [1:0]    mCh;
    int            mCnt;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (dre_writeEnable === 1'b1) begin
            checkVal("rd_wr_addr_equal", 32'(dre_readAddress), 32'(dre_writeAddress));
            checkVal("rd_wr_chan_equal", 32'(dre_readChannel), 32'(dre_writeChannel));
            if (sbq.size() == 0) begin
                checkVal("spurious_write", 32'(dre_writeEnable), 32'(0));
            end else begin
                wr_t e;
                e = sbq.pop_front();
                checkVal("wr_addr", 32'(dre_writeAddress), 32'(e.addr));
                checkVal("wr_chan", 32'(dre_writeChannel), 32'(e.chan));
                checkVal("wr_data", 32'(dre_writeData), 32'(e.data));
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
        dre_readData = 8'($urandom);
    endtask

    // Returns at the start of cycle T+LW/2+1, the first FILL cycle.
    task automatic startCmd(input logic [AW-1:0] addr, input logic [1:0] chn,
                            input int holdOff, input bit noise);
        cmd_valid   = 1'b1;
        cmd_addr    = addr;
        cmd_channel = chn;
        if (holdOff > 0) begin
            rw_idle = 1'b0;
            for (int i = 0; i < holdOff; i++) begin
                @(negedge clk);
                checkVal("holdoff_ready", 32'(cmd_ready), 32'(0));
                checkVal("holdoff_sel", 32'(sel), 32'(0));
                nextCycle();
            end
            rw_idle = 1'b1;
        end
        @(negedge clk);
        checkVal("cmd_ready", 32'(cmd_ready), 32'(1));
        checkVal("idle_sel", 32'(sel), 32'(0));
        mBase = addr & ~AW'(LW - 1);
        mCh   = chn;
        mCnt  = 0;
        for (int i = 0; i < LW / 2; i++) sbq.push_back('{mBase | AW'(2 * i), chn, 8'h00});
        nextCycle();
        cmd_valid   = 1'b0;
        cmd_addr    = AW'($urandom);
        cmd_channel = 2'($urandom);
        if (noise) begin
            beat_valid = 1'b1;
            abort      = 1'b1;
            rw_idle    = 1'b0;
        end
        for (int i = 0; i < LW / 2; i++) begin
            @(negedge clk);
            checkVal("clear_sel", 32'(sel), 32'(1));
            checkVal("clear_we", 32'(dre_writeEnable), 32'(1));
            checkVal("clear_beat_ready", 32'(beat_ready), 32'(0));
            nextCycle();
        end
        beat_valid = 1'b0;
        abort      = 1'b0;
        rw_idle    = 1'b1;
    endtask

    task automatic beatCycle(input bit v, input bit ab, output bit fin);
        beat_valid = v;
        abort      = ab;
        if (v) sbq.push_back('{mBase | AW'(mCnt), mCh, (mCnt[0] ? 8'hFF : 8'h0F)});
        @(negedge clk);
        checkVal("fill_beat_ready", 32'(beat_ready), 32'(1));
        checkVal("fill_sel", 32'(sel), 32'(1));
        if (!v) begin
            checkVal("gap_we", 32'(dre_writeEnable), 32'(0));
            checkVal("gap_addr", 32'(dre_writeAddress), 32'(mBase | AW'(mCnt)));
        end
        fin = ab || (v && (mCnt == LW - 1));
        nextCycle();
        beat_valid = 1'b0;
        abort      = 1'b0;
        if (v) mCnt++;
    endtask

    task automatic finishCheck();
        @(negedge clk);
        checkVal("done_pulse", 32'(done), 32'(1));
        checkVal("done_sel", 32'(sel), 32'(0));
        checkVal("done_beat_ready", 32'(beat_ready), 32'(0));
        checkVal("done_cmd_ready", 32'(cmd_ready), 32'(0));
        nextCycle();
        @(negedge clk);
        checkVal("done_one_cycle", 32'(done), 32'(0));
        checkVal("turnaround_ready", 32'(cmd_ready), 32'(rw_idle));
        checkVal("sb_drained", 32'(sbq.size()), 32'(0));
        nextCycle();
    endtask

    task automatic fullLine(input logic [AW-1:0] addr, input logic [1:0] chn);
        bit fin;
        startCmd(addr, chn, 0, 0);
        for (int i = 0; i < LW; i++) beatCycle(1'b1, 1'b0, fin);
        finishCheck();
    endtask

    initial begin
        bit fin;
        rst          = 1'b1;
        rw_idle      = 1'b1;
        cmd_valid    = 1'b0;
        cmd_channel  = 2'd0;
        cmd_addr     = '0;
        beat_valid   = 1'b0;
        abort        = 1'b0;
        dre_readData = 8'h00;
        nextCycle();
        @(negedge clk);
        checkVal("rst_sel", 32'(sel), 32'(0));
        checkVal("rst_done", 32'(done), 32'(0));
        checkVal("rst_we", 32'(dre_writeEnable), 32'(0));
        checkVal("rst_beat_ready", 32'(beat_ready), 32'(0));
        checkVal("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        checkVal("rst_addr", 32'(dre_writeAddress), 32'(0));
        checkVal("rst_data", 32'(dre_writeData), 32'(0));
        nextCycle();
        rst = 1'b0;
        rw_idle = 1'b0;
        #1;
        checkVal("idle_ready_follows_rw", 32'(cmd_ready), 32'(0));
        rw_idle = 1'b1;
        nextCycle();

        // Base 0x13 -> line 0x10, channel 2, back-to-back beats.
        fullLine(8'h13, 2'd2);

        // Gapped beats with beat/abort/rw_idle noise during CLEAR.
        startCmd(8'h2A, 2'd1, 0, 1);
        fin = 1'b0;
        for (int i = 0; i < 64 && !fin; i++) beatCycle((i % 3) == 0, 1'b0, fin);
        checkVal("gapped_finished", 32'(mCnt), 32'(LW));
        finishCheck();

        // Abort after three beats.
        startCmd(8'h45, 2'd3, 0, 1);
        for (int i = 0; i < 3; i++) beatCycle(1'b1, 1'b0, fin);
        beatCycle(1'b0, 1'b1, fin);
        finishCheck();

        // Abort coinciding with a beat: beat is still written.
        startCmd(8'h80, 2'd0, 0, 0);
        for (int i = 0; i < 2; i++) beatCycle(1'b1, 1'b0, fin);
        beatCycle(1'b1, 1'b1, fin);
        finishCheck();

        // Command held off for 5 cycles by rw_idle=0.
        startCmd(8'h60, 2'd1, 5, 0);
        for (int i = 0; i < LW; i++) beatCycle(1'b1, 1'b0, fin);
        finishCheck();

        // Reset in FILL on beat 4.
        startCmd(8'h38, 2'd2, 0, 0);
        for (int i = 0; i < 4; i++) beatCycle(1'b1, 1'b0, fin);
        beat_valid = 1'b1;
        #2;
        checkVal("pre_rst_we", 32'(dre_writeEnable), 32'(1));
        rst = 1'b1;
        #1;
        checkVal("async_rst_sel", 32'(sel), 32'(0));
        checkVal("async_rst_we", 32'(dre_writeEnable), 32'(0));
        checkVal("async_rst_beat_ready", 32'(beat_ready), 32'(0));
        nextCycle();
        beat_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checkVal("post_rst_ready", 32'(cmd_ready), 32'(1));
        checkVal("post_rst_addr", 32'(dre_writeAddress), 32'(0));
        checkVal("post_rst_sel", 32'(sel), 32'(0));
        nextCycle();
        fullLine(8'hF7, 2'd3);

        checkVal("sb_final_empty", 32'(sbq.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
